// File: rtl/sync_updown_counter_if.sv
// Control/status bundle for sync_updown_counter.
// The master side drives enable, direction, preset and flag-clear and
// observes the count and status; the counter sits on the slave side.
interface sync_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Clr_Flags;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             Wrap;
  logic             Ovf;
  logic             Unf;

  modport master (
    output En, Up, Load, D, Clr_Flags,
    input  Q, TC, Wrap, Ovf, Unf
  );

  modport slave (
    input  En, Up, Load, D, Clr_Flags,
    output Q, TC, Wrap, Ovf, Unf
  );
endinterface

// File: rtl/sync_updown_counter.sv
// Synchronous, presettable modulo-MODULUS up/down counter.
// Every count bit is a T flip-flop (J=K=T): the next state is q ^ t, where
// t is a per-bit toggle vector selected from the binary increment chain,
// the binary decrement chain, a wrap pattern or a preset pattern.
// TC is combinational so a cascaded stage advances on the same edge.
module sync_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input logic                   CLK,
  input logic                   Reset,
  sync_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] t_next;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] d_clamped;
  logic             wrap_reg;
  logic             ovf_reg;
  logic             unf_reg;
  logic             ovf_next;
  logic             unf_next;
  logic             at_max;
  logic             at_zero;
  logic             out_of_range;
  logic             wrap_up;
  logic             wrap_dn;

  assign at_max       = (q_reg == MAX_Q);
  assign at_zero      = (q_reg == '0);
  // Only reachable if the state is corrupted; used to force recovery.
  assign out_of_range = ({1'b0, q_reg} >= MOD_EXT);

  // Presets above the top count saturate to MODULUS-1.
  assign d_clamped = ({1'b0, bus.D} >= MOD_EXT) ? MAX_Q : bus.D;

  // Toggle chains: bit 0 always toggles; a higher bit toggles when all
  // lower bits are 1 (increment) or all are 0 (decrement).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign up_t[gi] = &q_reg[gi-1:0];
      assign dn_t[gi] = ~(|q_reg[gi-1:0]);
    end
  endgenerate

  // A wrap is the terminal count taken on an enabled, non-load edge.
  assign wrap_up = bus.En & ~bus.Load &  bus.Up & at_max;
  assign wrap_dn = bus.En & ~bus.Load & ~bus.Up & at_zero;

  // Select the toggle vector for the coming edge in priority order.
  always_comb begin
    t_next = '0;
    if (bus.Load) begin
      t_next = q_reg ^ d_clamped;
    end else if (bus.En) begin
      if (bus.Up) begin
        // Toggling every set bit lands on 0 (wrap or recovery).
        t_next = (at_max || out_of_range) ? q_reg : up_t;
      end else begin
        // From 0, toggling the bits of MAX_Q lands on MAX_Q.
        t_next = at_zero ? MAX_Q : dn_t;
      end
    end
  end

  // Sticky flags: clear request first, then a same-edge wrap sets again.
  always_comb begin
    ovf_next = (ovf_reg & ~bus.Clr_Flags) | wrap_up;
    unf_next = (unf_reg & ~bus.Clr_Flags) | wrap_dn;
  end

  // Count, wrap pulse and flag registers; reset clears them at once.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
    end else begin
      q_reg    <= q_reg ^ t_next;
      wrap_reg <= wrap_up | wrap_dn;
      ovf_reg  <= ovf_next;
      unf_reg  <= unf_next;
    end
  end

  assign bus.Q    = q_reg;
  assign bus.TC   = wrap_up | wrap_dn;
  assign bus.Wrap = wrap_reg;
  assign bus.Ovf  = ovf_reg;
  assign bus.Unf  = unf_reg;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: a MODULUS=10 counter driven from a vector
// table, plus a two-stage MODULUS=16 cascade for the reset/chain sequence.
module tb_sync_updown_counter;

  logic CLK;
  logic Reset;

  sync_updown_counter_if #(.WIDTH(4)) bus_a ();
  sync_updown_counter_if #(.WIDTH(4)) bus_lo ();
  sync_updown_counter_if #(.WIDTH(4)) bus_hi ();

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_a)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) dut_lo (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_lo)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) dut_hi (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_hi)
  );

  // Cascade: low stage terminal count enables the high stage.
  assign bus_hi.En        = bus_lo.TC;
  assign bus_hi.Up        = bus_lo.Up;
  assign bus_hi.Load      = 1'b0;
  assign bus_hi.D         = 4'd0;
  assign bus_hi.Clr_Flags = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic       clr;
    logic [3:0] d;
    logic       tc;    // TC before the edge, with these inputs applied
    logic [3:0] q;     // state after the edge
    logic       wrap;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[40];
  int   n_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic load, input logic en, input logic up, input logic clr,
                     input logic [3:0] d, input logic tc, input logic [3:0] q,
                     input logic wrap, input logic ovf, input logic unf);
    vecs[n_vec] = '{load, en, up, clr, d, tc, q, wrap, ovf, unf};
    n_vec++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_vec   = 0;

    // ---- vector table (MODULUS=10), state starts at Q=0, flags clear ----
    //      load en up clr d      tc  q     wrap ovf unf
    for (int i = 1; i <= 9; i++)
      add(0, 1, 1, 0, 4'd0,  0, 4'(i), 0, 0, 0);      // count up 1..9
    add(0, 1, 1, 0, 4'd0,  1, 4'd0,  1, 1, 0);        // up wrap 9->0
    add(0, 0, 1, 0, 4'd0,  0, 4'd0,  0, 1, 0);        // hold, pulse ends
    add(1, 0, 0, 0, 4'd1,  0, 4'd1,  0, 1, 0);        // load 1
    add(0, 1, 0, 0, 4'd0,  0, 4'd0,  0, 1, 0);        // down 1->0
    add(0, 1, 0, 0, 4'd0,  1, 4'd9,  1, 1, 1);        // down wrap 0->9
    add(0, 1, 1, 0, 4'd0,  1, 4'd0,  1, 1, 1);        // flip up, wrap again
    add(0, 0, 1, 1, 4'd0,  0, 4'd0,  0, 0, 0);        // clear flags
    add(1, 1, 1, 0, 4'd15, 0, 4'd9,  0, 0, 0);        // load clamp 15->9
    add(1, 1, 1, 0, 4'd3,  0, 4'd3,  0, 0, 0);        // load beats En at Q=9
    add(1, 1, 0, 0, 4'd0,  0, 4'd0,  0, 0, 0);        // load 0
    add(0, 0, 0, 0, 4'd0,  0, 4'd0,  0, 0, 0);        // En=0 masks TC
    add(0, 1, 0, 0, 4'd0,  1, 4'd9,  1, 0, 1);        // down wrap
    add(0, 1, 1, 0, 4'd0,  1, 4'd0,  1, 1, 1);        // up wrap, Ovf set
    add(1, 0, 1, 0, 4'd9,  0, 4'd9,  0, 1, 1);        // load 9
    add(0, 1, 1, 1, 4'd0,  1, 4'd0,  1, 1, 0);        // clear vs wrap: set wins
    add(0, 0, 1, 1, 4'd0,  0, 4'd0,  0, 0, 0);        // clear both flags
    add(1, 0, 0, 0, 4'd10, 0, 4'd9,  0, 0, 0);        // clamp just above range

    // ---- reset held: clock runs with En=1, nothing moves ----
    Reset = 1'b0;
    bus_a.En = 1'b1; bus_a.Up = 1'b0; bus_a.Load = 1'b0;
    bus_a.D = 4'd0;  bus_a.Clr_Flags = 1'b0;
    bus_lo.En = 1'b0; bus_lo.Up = 1'b1; bus_lo.Load = 1'b0;
    bus_lo.D = 4'd0;  bus_lo.Clr_Flags = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d q", i), 32'(bus_a.Q), 32'd0);
      check($sformatf("rst%0d flags", i), {29'd0, bus_a.Wrap, bus_a.Ovf, bus_a.Unf}, 32'd0);
      check($sformatf("rst%0d tc", i), 32'(bus_a.TC), 32'd1);
    end

    // ---- release and count up 1,2,3 ----
    bus_a.Up = 1'b1;
    Reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("rel%0d q", i), 32'(bus_a.Q), 32'(i));
    end

    // ---- async reset mid-count on the single counter ----
    #2 Reset = 1'b0;
    #1 check("async q", 32'(bus_a.Q), 32'd0);
    bus_a.En = 1'b0;
    #1 Reset = 1'b1;
    step();

    // ---- table ----
    for (int i = 0; i < n_vec; i++) begin
      bus_a.Load = vecs[i].load;
      bus_a.En = vecs[i].en;
      bus_a.Up = vecs[i].up;
      bus_a.Clr_Flags = vecs[i].clr;
      bus_a.D = vecs[i].d;
      #1;
      check($sformatf("v%0d tc", i), 32'(bus_a.TC), 32'(vecs[i].tc));
      step();
      check($sformatf("v%0d q", i), 32'(bus_a.Q), 32'(vecs[i].q));
      check($sformatf("v%0d wrap", i), 32'(bus_a.Wrap), 32'(vecs[i].wrap));
      check($sformatf("v%0d ovf", i), 32'(bus_a.Ovf), 32'(vecs[i].ovf));
      check($sformatf("v%0d unf", i), 32'(bus_a.Unf), 32'(vecs[i].unf));
    end
    bus_a.Load = 1'b0; bus_a.En = 1'b0; bus_a.Clr_Flags = 1'b0;

    // ---- cascade: 20 up edges -> 0x14 ----
    bus_lo.En = 1'b1;
    bus_lo.Up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 16) begin
        check("casc16 value", {24'd0, bus_hi.Q, bus_lo.Q}, 32'h10);
        check("casc16 lo wrap", 32'(bus_lo.Wrap), 32'd1);
      end
    end
    check("casc20 value", {24'd0, bus_hi.Q, bus_lo.Q}, 32'h14);
    check("casc lo ovf", 32'(bus_lo.Ovf), 32'd1);
    check("casc hi ovf", 32'(bus_hi.Ovf), 32'd0);

    // Reset pulse between edges clears both stages with no clock edge.
    #2 Reset = 1'b0;
    #1;
    check("casc async value", {24'd0, bus_hi.Q, bus_lo.Q}, 32'h00);
    check("casc async ovf", 32'(bus_lo.Ovf), 32'd0);
    #1 Reset = 1'b1;
    step();
    check("casc first edge", {24'd0, bus_hi.Q, bus_lo.Q}, 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
